// File: rtl/bsg_link_sdr_upstream_serializer.sv
// Single-clock SDR link transmitter: buffers core words in a small FIFO and serializes them
// LSB phit first, gated by a credit count that the receiver replenishes through a toggling token.
module bsg_link_sdr_upstream_serializer #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PHIT_W      = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned CREDITS     = 8,
   parameter int unsigned TOKEN_BATCH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_W-1:0]                 core_data_i,
   input  logic                              core_valid_i,
   output logic                              core_ready_o,
   output logic [PHIT_W-1:0]                 io_data_o,
   output logic                              io_valid_o,
   input  logic                              io_token_i,
   output logic [$clog2(CREDITS+1)-1:0]      credits_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
   output logic                              credit_err_o
);
   localparam int unsigned BEATS  = DATA_W / PHIT_W;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CRED_W = $clog2(CREDITS + 1);
   localparam int unsigned SUM_W  = CRED_W + 1;

   typedef enum logic {S_IDLE, S_SEND} state_e;

   state_e               state_q;
   logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [FCNT_W-1:0]    count_q;
   logic [DATA_W-1:0]    shift_q;
   logic [BEAT_W-1:0]    beat_q;
   logic [CRED_W-1:0]    credits_q;
   logic                 tok_q;
   logic                 err_q;

   logic                 push;
   logic                 load;
   logic                 last_beat;
   logic                 tok_edge;
   logic [BEAT_W-1:0]    beat_nxt;
   logic [SUM_W-1:0]     credit_sum;

   assign core_ready_o = (count_q < FCNT_W'(FIFO_DEPTH));
   assign credits_o    = credits_q;
   assign fifo_count_o = count_q;
   assign credit_err_o = err_q;

   // Load decision uses registered credits only; a token return in this cycle helps next cycle.
   always_comb begin
      push       = core_valid_i & core_ready_o;
      last_beat  = (beat_q == BEAT_W'(BEATS - 1));
      load       = ((state_q == S_IDLE) || ((state_q == S_SEND) && last_beat))
                   && (count_q != '0) && (credits_q != '0);
      tok_edge   = io_token_i ^ tok_q;
      beat_nxt   = beat_q + 1'b1;
      credit_sum = SUM_W'(credits_q) - SUM_W'(load)
                   + (tok_edge ? SUM_W'(TOKEN_BATCH) : SUM_W'(0));
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= core_data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         beat_q     <= '0;
         credits_q  <= CRED_W'(CREDITS);
         tok_q      <= 1'b0;
         err_q      <= 1'b0;
         io_valid_o <= 1'b0;
         io_data_o  <= '0;
      end else begin
         tok_q <= io_token_i;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + FCNT_W'(push) - FCNT_W'(load);

         // Over-return means the receiver and this side disagree; clamp and flag it.
         if (credit_sum > SUM_W'(CREDITS)) begin
            credits_q <= CRED_W'(CREDITS);
            err_q     <= 1'b1;
         end else begin
            credits_q <= CRED_W'(credit_sum);
         end

         if (load) begin
            shift_q    <= mem_q[rd_ptr_q];
            io_data_o  <= mem_q[rd_ptr_q][PHIT_W-1:0];
            io_valid_o <= 1'b1;
            beat_q     <= '0;
            state_q    <= S_SEND;
         end else if (state_q == S_SEND) begin
            if (last_beat) begin
               io_valid_o <= 1'b0;
               state_q    <= S_IDLE;
            end else begin
               beat_q    <= beat_nxt;
               io_data_o <= shift_q[PHIT_W*beat_nxt +: PHIT_W];
            end
         end
      end
   end
endmodule

// File: tb/tb_bsg_link_sdr_upstream_serializer.sv
// Directed bench for the SDR upstream serializer; a phit scoreboard is filled on every push
// and drained whenever io_valid_o is seen.
module tb_bsg_link_sdr_upstream_serializer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] core_data_i;
   logic        core_valid_i;
   logic        core_ready_o;
   logic [7:0]  io_data_o;
   logic        io_valid_o;
   logic        io_token_i;
   logic [3:0]  credits_o;
   logic [2:0]  fifo_count_o;
   logic        credit_err_o;

   bsg_link_sdr_upstream_serializer dut (
      .clk(clk), .rst_n(rst_n),
      .core_data_i(core_data_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
      .io_data_o(io_data_o), .io_valid_o(io_valid_o), .io_token_i(io_token_i),
      .credits_o(credits_o), .fifo_count_o(fifo_count_o), .credit_err_o(credit_err_o)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         vcnt  = 0;
   int         first_v = -1;
   int         last_v  = -1;
   logic [7:0] sbq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled on the falling edge and valid phits are scored.
   task automatic tick();
      logic [7:0] e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (io_valid_o === 1'b1) begin
         vcnt++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
         check("phit_expected", 32'(sbq.size() > 0), 32'd1);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("phit_data", 32'(io_data_o), 32'(e));
         end
      end
   endtask

   task automatic do_reset();
      sbq.delete();
      rst_n = 1'b0; core_valid_i = 1'b0; core_data_i = '0; io_token_i = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      vcnt = 0; first_v = -1; last_v = -1;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 64; i++) begin
         if (core_ready_o === 1'b1) break;
         tick();
      end
      check("ready_timeout", 32'(core_ready_o), 32'd1);
      core_data_i  = w;
      core_valid_i = 1'b1;
      for (int b = 0; b < 4; b++) sbq.push_back(w[8*b +: 8]);
      tick();
      core_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (io_valid_o === 1'b0 && fifo_count_o === 3'd0) break;
         tick();
      end
      check("idle_timeout", {31'd0, io_valid_o}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      // T1 reset state
      do_reset();
      check("rst_credits", 32'(credits_o), 32'd8);
      check("rst_valid", 32'(io_valid_o), 32'd0);
      check("rst_ready", 32'(core_ready_o), 32'd1);
      check("rst_count", 32'(fifo_count_o), 32'd0);
      check("rst_err", 32'(credit_err_o), 32'd0);
      check("rst_data", 32'(io_data_o), 32'd0);

      // T2 single word: latency, order, credits
      push_word(32'hDDCCBBAA);
      check("t2_valid_edge_t", 32'(io_valid_o), 32'd0);
      check("t2_count_edge_t", 32'(fifo_count_o), 32'd1);
      tick();
      check("t2_valid_edge_t1", 32'(io_valid_o), 32'd1);
      check("t2_credits", 32'(credits_o), 32'd7);
      check("t2_count_after_load", 32'(fifo_count_o), 32'd0);
      wait_idle();
      check("t2_valid_cycles", 32'(vcnt), 32'd4);
      check("t2_data_hold", 32'(io_data_o), 32'hDD);
      check("t2_sb_empty", 32'(sbq.size()), 32'd0);

      // T3 back-to-back words
      do_reset();
      push_word(32'h03020100);
      push_word(32'h13121110);
      push_word(32'h23222120);
      wait_idle();
      check("t3_valid_cycles", 32'(vcnt), 32'd12);
      check("t3_contiguous", 32'(last_v - first_v + 1), 32'd12);
      check("t3_credits", 32'(credits_o), 32'd5);
      check("t3_sb_empty", 32'(sbq.size()), 32'd0);

      // T4 credit stall and token replenish
      do_reset();
      for (int i = 0; i < 12; i++) push_word($urandom);
      for (int i = 0; i < 200; i++) begin
         if (credits_o === 4'd0 && io_valid_o === 1'b0) break;
         tick();
      end
      for (int i = 0; i < 5; i++) tick();
      check("t4_valid_cycles", 32'(vcnt), 32'd32);
      check("t4_credits", 32'(credits_o), 32'd0);
      check("t4_valid", 32'(io_valid_o), 32'd0);
      check("t4_count", 32'(fifo_count_o), 32'd4);
      check("t4_ready", 32'(core_ready_o), 32'd0);
      io_token_i = 1'b1;
      tick();
      check("t4_tok_credits", 32'(credits_o), 32'd2);
      check("t4_tok_valid", 32'(io_valid_o), 32'd0);
      tick();
      check("t4_resume_valid", 32'(io_valid_o), 32'd1);
      check("t4_resume_credits", 32'(credits_o), 32'd1);
      check("t4_resume_count", 32'(fifo_count_o), 32'd3);
      for (int i = 0; i < 40; i++) begin
         if (io_valid_o === 1'b0) break;
         tick();
      end
      check("t4_valid_cycles2", 32'(vcnt), 32'd40);
      check("t4_credits2", 32'(credits_o), 32'd0);
      check("t4_count2", 32'(fifo_count_o), 32'd2);

      // T5a token return in the same cycle as a load at credits=1
      do_reset();
      for (int i = 0; i < 7; i++) push_word($urandom);
      wait_idle();
      check("t5_credits1", 32'(credits_o), 32'd1);
      push_word(32'h5A5A5A5A);
      io_token_i = 1'b1;
      tick();
      check("t5_net_credits", 32'(credits_o), 32'd2);
      check("t5_net_valid", 32'(io_valid_o), 32'd1);
      wait_idle();
      check("t5_credits_after", 32'(credits_o), 32'd2);
      check("t5_err_clear", 32'(credit_err_o), 32'd0);

      // T5b over-return saturates and sets the sticky error
      do_reset();
      push_word(32'h11223344);
      wait_idle();
      check("t5b_credits7", 32'(credits_o), 32'd7);
      io_token_i = 1'b1;
      tick();
      check("t5b_sat_credits", 32'(credits_o), 32'd8);
      check("t5b_err", 32'(credit_err_o), 32'd1);
      io_token_i = 1'b0;
      tick();
      check("t5b_sat_credits2", 32'(credits_o), 32'd8);
      tick();
      check("t5b_err_sticky", 32'(credit_err_o), 32'd1);

      // T6 reset during beat 2
      do_reset();
      push_word(32'h44332211);
      push_word(32'h88776655);
      tick();
      tick();
      check("t6_beat2_data", 32'(io_data_o), 32'h33);
      rst_n = 1'b0;
      sbq.delete();
      tick();
      check("t6_valid", 32'(io_valid_o), 32'd0);
      check("t6_count", 32'(fifo_count_o), 32'd0);
      check("t6_credits", 32'(credits_o), 32'd8);
      check("t6_err", 32'(credit_err_o), 32'd0);
      rst_n = 1'b1;
      v0 = vcnt;
      for (int i = 0; i < 10; i++) tick();
      check("t6_no_residual", 32'(vcnt), 32'(v0));
      check("t6_ready", 32'(core_ready_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
